// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control bit positions, funct3 codes,
// FSM encoding and the store-lane / load-extraction helpers.
package mem_stage_pkg;

  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Unlisted funct3 values on a memory op fall back to a word access.
  function automatic size_t decode_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: decode_size = SZ_B;
      F3_H, F3_HU: decode_size = SZ_H;
      default:     decode_size = SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_H:    is_misaligned = a[0];
      SZ_W:    is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_B:    store_be = 4'b0001 << a;
      SZ_H:    store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the low bytes puts the data on every lane; the byte enables pick the target.
  function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_B:    store_lanes = {4{d[7:0]}};
      SZ_H:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    load_extract = {{24{b[7]}}, b};
      F3_BU:   load_extract = {24'd0, b};
      F3_H:    load_extract = {{16{h[15]}}, h};
      F3_HU:   load_extract = {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_pipe_ram.sv
// Byte-enabled single-port data RAM: one bank per byte lane, synchronous write and
// registered read, contents never reset.
module data_ram_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank [DEPTH_WORDS];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        bank[addr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        rd_reg <= bank[addr];
      end
    end

    assign rdata[8*gi +: 8] = rd_reg;
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage between EX and WB: branch resolution, byte/half/word loads and stores against
// the internal RAM with optional wait states, and the registered MEM/WB bundle.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_zero_flag,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_data,
  input  logic [7:0]      in_control,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_reg_addr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_regdata,
  output logic [XLEN-1:0] out_memdata,
  output logic [7:0]      out_control,
  output logic [4:0]      out_reg_addr,
  output logic            out_pcsrc,
  output logic            out_misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;

  logic [XLEN-1:0] req_pc_reg, req_addr_reg, req_data_reg;
  logic [7:0]      req_control_reg;
  logic [2:0]      req_funct3_reg;
  logic            req_zero_reg;
  logic [4:0]      req_reg_addr_reg;

  logic            ld_done_reg;
  logic [2:0]      ld_funct3_reg;
  logic [1:0]      ld_lane_reg;
  logic [XLEN-1:0] memdata_hold_reg;

  logic            accept, in_memop, in_misal, go_busy, busy_done, complete_imm, complete;
  logic [XLEN-1:0] src_pc, src_addr, src_data;
  logic [7:0]      src_control;
  logic [2:0]      src_funct3;
  logic            src_zero;
  logic [4:0]      src_reg_addr;
  size_t           src_size;
  logic            src_memop, src_misal, src_store, src_load, src_pcsrc, access_fire;
  logic [31:0]     ram_rdata, load_val;

  assign in_ready = rst_n && (state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;

  assign in_memop     = in_control[CTRL_MEMWRITE] || in_control[CTRL_MEMREAD];
  assign in_misal     = in_memop && is_misaligned(decode_size(in_funct3), in_addr[1:0]);
  assign go_busy      = accept && in_memop && !in_misal && (MEM_LATENCY != 0);
  assign busy_done    = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);
  assign complete_imm = accept && !go_busy;
  assign complete     = complete_imm || busy_done;

  // Completion source: live inputs for single-cycle ops, the held request after wait states.
  always_comb begin
    src_pc       = in_pc;
    src_addr     = in_addr;
    src_data     = in_data;
    src_control  = in_control;
    src_funct3   = in_funct3;
    src_zero     = in_zero_flag;
    src_reg_addr = in_reg_addr;
    if (busy_done) begin
      src_pc       = req_pc_reg;
      src_addr     = req_addr_reg;
      src_data     = req_data_reg;
      src_control  = req_control_reg;
      src_funct3   = req_funct3_reg;
      src_zero     = req_zero_reg;
      src_reg_addr = req_reg_addr_reg;
    end
  end

  assign src_size    = decode_size(src_funct3);
  assign src_memop   = src_control[CTRL_MEMWRITE] || src_control[CTRL_MEMREAD];
  assign src_misal   = src_memop && is_misaligned(src_size, src_addr[1:0]);
  assign src_store   = src_control[CTRL_MEMWRITE];
  assign src_load    = src_control[CTRL_MEMREAD] && !src_control[CTRL_MEMWRITE];
  assign src_pcsrc   = src_control[CTRL_BRANCH] &&
                       ((src_funct3 == F3_BNE) ? !src_zero : src_zero);
  assign access_fire = busy_done || (complete_imm && src_memop && !src_misal);

  data_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (access_fire && src_store),
    .re   (access_fire && src_load),
    .be   (store_be(src_size, src_addr[1:0])),
    .addr (src_addr[AW+1:2]),
    .wdata(store_lanes(src_size, src_data)),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (go_busy) begin
          state_next = ST_BUSY;
          cnt_next   = LAT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= 4'd0;
      req_pc_reg       <= '0;
      req_addr_reg     <= '0;
      req_data_reg     <= '0;
      req_control_reg  <= '0;
      req_funct3_reg   <= '0;
      req_zero_reg     <= 1'b0;
      req_reg_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        req_pc_reg       <= in_pc;
        req_addr_reg     <= in_addr;
        req_data_reg     <= in_data;
        req_control_reg  <= in_control;
        req_funct3_reg   <= in_funct3;
        req_zero_reg     <= in_zero_flag;
        req_reg_addr_reg <= in_reg_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_pc           <= '0;
      out_regdata      <= '0;
      out_control      <= '0;
      out_reg_addr     <= '0;
      out_pcsrc        <= 1'b0;
      out_misalign     <= 1'b0;
      ld_done_reg      <= 1'b0;
      ld_funct3_reg    <= '0;
      ld_lane_reg      <= '0;
      memdata_hold_reg <= '0;
    end else begin
      out_valid   <= complete;
      ld_done_reg <= complete && src_load && !src_misal;
      if (complete) begin
        out_pc       <= src_pc;
        out_regdata  <= src_addr;
        out_control  <= src_control;
        out_reg_addr <= src_reg_addr;
        out_pcsrc    <= src_pcsrc;
        out_misalign <= src_misal;
      end
      if (complete && src_load && !src_misal) begin
        ld_funct3_reg <= src_funct3;
        ld_lane_reg   <= src_addr[1:0];
      end
      if (ld_done_reg) begin
        memdata_hold_reg <= load_val;
      end
    end
  end

  // RAM read data is only valid in the completion cycle; afterwards the held copy is shown.
  assign load_val    = load_extract(ld_funct3_reg, ld_lane_reg, ram_rdata);
  assign out_memdata = ld_done_reg ? load_val : memdata_hold_reg;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: three instances with memory latency 0, 3 and 2
// share the data inputs and each has its own valid and reset.
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic [2:0]  rst_n_v;
  logic [2:0]  in_valid_v;
  logic [31:0] in_pc, in_addr, in_data;
  logic        in_zero_flag;
  logic [7:0]  in_control;
  logic [2:0]  in_funct3;
  logic [4:0]  in_reg_addr;

  logic        in_ready_v     [3];
  logic        out_valid_v    [3];
  logic [31:0] out_pc_v       [3];
  logic [31:0] out_regdata_v  [3];
  logic [31:0] out_memdata_v  [3];
  logic [7:0]  out_control_v  [3];
  logic [4:0]  out_reg_addr_v [3];
  logic        out_pcsrc_v    [3];
  logic        out_misalign_v [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
    mem_stage_pipe #(
      .XLEN(32), .DEPTH_WORDS(1024), .MEM_LATENCY(LAT)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n_v[gi]),
      .in_valid    (in_valid_v[gi]),
      .in_ready    (in_ready_v[gi]),
      .in_pc       (in_pc),
      .in_zero_flag(in_zero_flag),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .in_control  (in_control),
      .in_funct3   (in_funct3),
      .in_reg_addr (in_reg_addr),
      .out_valid   (out_valid_v[gi]),
      .out_pc      (out_pc_v[gi]),
      .out_regdata (out_regdata_v[gi]),
      .out_memdata (out_memdata_v[gi]),
      .out_control (out_control_v[gi]),
      .out_reg_addr(out_reg_addr_v[gi]),
      .out_pcsrc   (out_pcsrc_v[gi]),
      .out_misalign(out_misalign_v[gi])
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Presents one instruction to instance d, waits for accept, then for out_valid.
  // lat = cycles after N+1 until out_valid.
  task automatic issue(input int d, input logic [7:0] ctrl, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input logic zero,
                       input logic [31:0] pc, output int lat);
    logic acc;
    acc          = 1'b0;
    lat          = -1;
    in_control   = ctrl;
    in_funct3    = f3;
    in_addr      = addr;
    in_data      = data;
    in_zero_flag = zero;
    in_pc        = pc;
    in_reg_addr  = 5'd7;
    in_valid_v[d] = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready_v[d];
      @(posedge clk);
      #1;
    end
    in_valid_v[d] = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    lat = 0;
    while (!out_valid_v[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_v[d]) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    rst_n_v      = 3'b000;
    in_valid_v   = 3'b000;
    in_pc        = '0;
    in_addr      = '0;
    in_data      = '0;
    in_zero_flag = 1'b0;
    in_control   = '0;
    in_funct3    = '0;
    in_reg_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready_v[0]), 32'd0);
    chk("rst_valid", 32'(out_valid_v[0]), 32'd0);
    chk("rst_memdata", out_memdata_v[0], 32'd0);
    chk("rst_pc", out_pc_v[0], 32'd0);
    @(negedge clk);
    rst_n_v = 3'b111;
    #1;
    chk("ready_after_rst", 32'(in_ready_v[0]), 32'd1);
    @(posedge clk);
    #1;

    // ---- latency 0 ----
    issue(0, 8'h08, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h100, lat);
    chk("sw_lat", 32'(lat), 32'd0);
    chk("sw_regdata", out_regdata_v[0], 32'h10);
    chk("sw_misalign", 32'(out_misalign_v[0]), 32'd0);
    issue(0, 8'h10, 3'b010, 32'h10, 32'h0, 1'b0, 32'h104, lat);
    chk("lw_lat", 32'(lat), 32'd0);
    chk("lw_data", out_memdata_v[0], 32'hDEADBEEF);
    chk("lw_pc", out_pc_v[0], 32'h104);
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(out_valid_v[0]), 32'd0);
    chk("memdata_hold", out_memdata_v[0], 32'hDEADBEEF);

    issue(0, 8'h08, 3'b000, 32'h13, 32'h00000080, 1'b0, 32'h108, lat);
    issue(0, 8'h10, 3'b000, 32'h13, 32'h0, 1'b0, 32'h10C, lat);
    chk("lb_13", out_memdata_v[0], 32'hFFFFFF80);
    issue(0, 8'h10, 3'b100, 32'h13, 32'h0, 1'b0, 32'h110, lat);
    chk("lbu_13", out_memdata_v[0], 32'h00000080);
    issue(0, 8'hF1, 3'b010, 32'h10, 32'h0, 1'b0, 32'h114, lat);
    chk("lw_after_sb", out_memdata_v[0], 32'h80ADBEEF);
    chk("ctrl_pass", 32'(out_control_v[0]), 32'hF1);
    chk("reg_addr", 32'(out_reg_addr_v[0]), 32'd7);
    issue(0, 8'h10, 3'b001, 32'h12, 32'h0, 1'b0, 32'h118, lat);
    chk("lh_12", out_memdata_v[0], 32'hFFFF80AD);
    issue(0, 8'h10, 3'b101, 32'h12, 32'h0, 1'b0, 32'h11C, lat);
    chk("lhu_12", out_memdata_v[0], 32'h000080AD);

    issue(0, 8'h10, 3'b001, 32'h11, 32'h0, 1'b0, 32'h120, lat);
    chk("lh_mis_lat", 32'(lat), 32'd0);
    chk("lh_mis_flag", 32'(out_misalign_v[0]), 32'd1);
    chk("lh_mis_memdata", out_memdata_v[0], 32'h000080AD);
    issue(0, 8'h08, 3'b010, 32'h12, 32'h12345678, 1'b0, 32'h124, lat);
    chk("sw_mis_flag", 32'(out_misalign_v[0]), 32'd1);
    issue(0, 8'h10, 3'b010, 32'h10, 32'h0, 1'b0, 32'h128, lat);
    chk("lw_unchanged", out_memdata_v[0], 32'h80ADBEEF);
    chk("lw_aligned_flag", 32'(out_misalign_v[0]), 32'd0);

    issue(0, 8'h08, 3'b010, 32'h1010, 32'h11223344, 1'b0, 32'h12C, lat);
    issue(0, 8'h10, 3'b010, 32'h10, 32'h0, 1'b0, 32'h130, lat);
    chk("addr_wrap", out_memdata_v[0], 32'h11223344);

    issue(0, 8'h04, 3'b001, 32'h0, 32'h0, 1'b0, 32'h134, lat);
    chk("bne_nz", 32'(out_pcsrc_v[0]), 32'd1);
    issue(0, 8'h04, 3'b000, 32'h0, 32'h0, 1'b0, 32'h138, lat);
    chk("beq_nz", 32'(out_pcsrc_v[0]), 32'd0);
    issue(0, 8'h04, 3'b000, 32'h0, 32'h0, 1'b1, 32'h13C, lat);
    chk("beq_z", 32'(out_pcsrc_v[0]), 32'd1);
    issue(0, 8'h04, 3'b001, 32'h0, 32'h0, 1'b1, 32'h140, lat);
    chk("bne_z", 32'(out_pcsrc_v[0]), 32'd0);

    in_control    = 8'h01;
    in_funct3     = 3'b000;
    in_pc         = 32'h200;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_pc = 32'h204;
    chk("b2b_valid0", 32'(out_valid_v[0]), 32'd1);
    chk("b2b_pc0", out_pc_v[0], 32'h200);
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    chk("b2b_valid1", 32'(out_valid_v[0]), 32'd1);
    chk("b2b_pc1", out_pc_v[0], 32'h204);
    @(posedge clk);
    #1;
    chk("b2b_idle", 32'(out_valid_v[0]), 32'd0);
    chk("b2b_pc_hold", out_pc_v[0], 32'h204);

    // ---- latency 3 ----
    issue(1, 8'h08, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h400, lat);
    chk("l3_sw_lat", 32'(lat), 32'd3);
    in_control    = 8'h10;
    in_addr       = 32'h20;
    in_pc         = 32'h404;
    in_valid_v[1] = 1'b1;
    chk("l3_ready_n", 32'(in_ready_v[1]), 32'd1);
    @(posedge clk);
    #1;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("l3_busy_ready_%0d", c), 32'(in_ready_v[1]), 32'd0);
      chk($sformatf("l3_busy_valid_%0d", c), 32'(out_valid_v[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("l3_done_valid", 32'(out_valid_v[1]), 32'd1);
    chk("l3_done_data", out_memdata_v[1], 32'hCAFEF00D);
    chk("l3_done_ready", 32'(in_ready_v[1]), 32'd1);
    @(posedge clk);
    #1;
    in_valid_v[1] = 1'b0;
    chk("l3_reaccept", 32'(in_ready_v[1]), 32'd0);
    k = 0;
    while (!out_valid_v[1] && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("l3_second_lat", 32'(k), 32'd3);
    chk("l3_second_data", out_memdata_v[1], 32'hCAFEF00D);

    // ---- latency 2, reset while busy ----
    issue(2, 8'h08, 3'b010, 32'h40, 32'h55555555, 1'b0, 32'h300, lat);
    chk("l2_sw_lat", 32'(lat), 32'd2);
    chk("l2_sw_pc", out_pc_v[2], 32'h300);
    in_control    = 8'h08;
    in_funct3     = 3'b010;
    in_addr       = 32'h40;
    in_data       = 32'hAAAAAAAA;
    in_pc         = 32'h304;
    in_valid_v[2] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[2] = 1'b0;
    rst_n_v[2]    = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid_v[2]), 32'd0);
    chk("abort_pc", out_pc_v[2], 32'd0);
    chk("abort_regdata", out_regdata_v[2], 32'd0);
    chk("abort_ready", 32'(in_ready_v[2]), 32'd0);
    k = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_v[2]) k++;
    end
    chk("abort_no_valid", 32'(k), 32'd0);
    @(negedge clk);
    rst_n_v[2] = 1'b1;
    @(posedge clk);
    #1;
    issue(2, 8'h10, 3'b010, 32'h40, 32'h0, 1'b0, 32'h308, lat);
    chk("abort_old_word", out_memdata_v[2], 32'h55555555);
    chk("abort_lw_lat", 32'(lat), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
